// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-unit bundle; misalign_err only exists with INSTR_FETCH_MISALIGN_CHECK_EN
interface instr_fetch_if;
  logic        stall;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
  modport master(input stall, jump_enable, jump_addr, imem_rdata, imem_ready,
                 output imem_req, imem_addr, instr, pc_out, instr_valid, misalign_err);
  modport slave(output stall, jump_enable, jump_addr, imem_rdata, imem_ready,
                input imem_req, imem_addr, instr, pc_out, instr_valid, misalign_err);
`else
  modport master(input stall, jump_enable, jump_addr, imem_rdata, imem_ready,
                 output imem_req, imem_addr, instr, pc_out, instr_valid);
  modport slave(output stall, jump_enable, jump_addr, imem_rdata, imem_ready,
                input imem_req, imem_addr, instr, pc_out, instr_valid);
`endif
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: pc sequencer with 1-entry skid; INSTR_FETCH_MISALIGN_CHECK_EN adds misaligned-jump rejection
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;
  state_t      state;
  logic [31:0] pc, skid_data, skid_pc;
  logic        skid_valid;
  logic        jmp, free;
  logic [31:0] target;
  assign target = bus.jump_addr & ~32'h3;
  assign free = !bus.instr_valid || !bus.stall;
  assign bus.imem_req = state == REQ || state == DROP;
  assign bus.imem_addr = pc;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic bad_jump;
  assign bad_jump = bus.jump_enable && |bus.jump_addr[1:0];
  assign jmp = bus.jump_enable && !bad_jump;
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.misalign_err <= 1'b0;
    else bus.misalign_err <= bad_jump;
`else
  assign jmp = bus.jump_enable;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      skid_valid      <= 1'b0;
      skid_data       <= 32'h0;
      skid_pc         <= 32'h0;
      bus.instr       <= NOP_INSTR;
      bus.pc_out      <= 32'h0;
      bus.instr_valid <= 1'b0;
    end else if (jmp) begin
      pc              <= target;
      bus.instr_valid <= 1'b0;
      bus.instr       <= NOP_INSTR;
      skid_valid      <= 1'b0;
      state           <= state == REQ ? (bus.imem_ready ? IDLE : DROP) : state == DROP ? DROP : IDLE;
    end else begin
      if (bus.instr_valid && !bus.stall) begin
        bus.instr_valid <= 1'b0;
        bus.instr       <= NOP_INSTR;
      end
      case (state)
        IDLE: if (free) state <= REQ;
        REQ: if (bus.imem_ready) begin
          pc <= pc + 32'd4;
          if (free) begin
            bus.instr       <= bus.imem_rdata;
            bus.pc_out      <= pc;
            bus.instr_valid <= 1'b1;
          end else begin
            skid_data  <= bus.imem_rdata;
            skid_pc    <= pc;
            skid_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        DROP: if (bus.imem_ready) state <= REQ;
        HOLD: if (!bus.stall) begin
          bus.instr       <= skid_data;
          bus.pc_out      <= skid_pc;
          bus.instr_valid <= 1'b1;
          skid_valid      <= 1'b0;
          state           <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
